btn_shape_seq: RTL and testbench

BTN_SHAPE_SEQ -- requirements
Module: btn_shape_seq

---
 rtl/btn_pkg.sv | 28 ++
 rtl/tick_gen.sv | 32 +++
 rtl/btn_shape_seq.sv | 203 ++++++++++++++++++++
 tb/tb_btn_shape_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button shape selector:
// debounce FSM state encoding, output counter width, default timing
// constants and a counter-width helper.
package btn_pkg;

    // Debounce FSM states: two stable levels and two candidate levels.
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        HELD_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } btn_state_t;

    // Width of the shape-select index.
    localparam int COUNT_W = 3;

    // Defaults for a 100 MHz clock and a 1 kHz tick.
    localparam int DEF_TICK_DIV            = 100000;
    localparam int DEF_DEBOUNCE_TICKS      = 200;
    localparam int DEF_REPEAT_DELAY_TICKS  = 500;
    localparam int DEF_REPEAT_PERIOD_TICKS = 250;

    // Number of bits needed to hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Tick enable generator: a free-running divider that raises tick for
// exactly one clk out of every TICK_DIV. No derived clocks are created;
// downstream logic uses tick as a clock enable.
module tick_gen
    import btn_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_reg;

    // Divider counts 0..TICK_DIV-1 and wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg <= '0;
        end else if (div_reg == DIV_LAST) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + 1'b1;
        end
    end

    assign tick = (div_reg == DIV_LAST);

endmodule

// File: rtl/btn_shape_seq.sv
// Push-button shape selector: synchronizes a raw bouncing button,
// debounces it with a tick-paced four-state FSM, and advances a 3-bit
// shape index (wrapping 7->0) once per accepted press.
// Optional feature: define BTN_AUTO_REPEAT_EN to emit additional presses
// while the button is held (first after REPEAT_DELAY_TICKS, then every
// REPEAT_PERIOD_TICKS). Without the macro no repeat logic is built.
module btn_shape_seq
    import btn_pkg::*;
#(
    parameter int TICK_DIV            = DEF_TICK_DIV,
    parameter int DEBOUNCE_TICKS      = DEF_DEBOUNCE_TICKS,
    parameter int REPEAT_DELAY_TICKS  = DEF_REPEAT_DELAY_TICKS,
    parameter int REPEAT_PERIOD_TICKS = DEF_REPEAT_PERIOD_TICKS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btnU,
    output logic               btn_level,
    output logic               press_pulse,
    output logic [COUNT_W-1:0] count
);

    localparam int STAB_W = cnt_width(DEBOUNCE_TICKS);
    localparam logic [STAB_W-1:0] STAB_DONE = STAB_W'(DEBOUNCE_TICKS);

    // ------------------------------------------------------------------
    // Input synchronizer and tick enable
    // ------------------------------------------------------------------
    logic [1:0] sync_reg;
    logic       btn_sync;
    logic       tick;

    // Two-flop synchronizer; only sync_reg[1] is used downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], btnU};
        end
    end

    assign btn_sync = sync_reg[1];

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // ------------------------------------------------------------------
    // Debounce FSM and shape counter
    // ------------------------------------------------------------------
    btn_state_t          state_reg, state_next;
    logic [STAB_W-1:0]   stab_reg, stab_next, stab_inc;
    logic [COUNT_W-1:0]  count_reg, count_next;
    logic                pulse_reg, pulse_next;
    logic                press;

    assign stab_inc = stab_reg + 1'b1;

`ifdef BTN_AUTO_REPEAT_EN
    // ------------------------------------------------------------------
    // Auto-repeat: counts ticks while stably held. The first repeat needs
    // REPEAT_DELAY_TICKS; once armed, each later one needs
    // REPEAT_PERIOD_TICKS. Any exit from HELD_HIGH disarms and clears.
    // ------------------------------------------------------------------
    localparam int REP_MAX = (REPEAT_DELAY_TICKS > REPEAT_PERIOD_TICKS)
                             ? REPEAT_DELAY_TICKS : REPEAT_PERIOD_TICKS;
    localparam int REP_W = cnt_width(REP_MAX);
    localparam logic [REP_W-1:0] REP_DELAY  = REP_W'(REPEAT_DELAY_TICKS);
    localparam logic [REP_W-1:0] REP_PERIOD = REP_W'(REPEAT_PERIOD_TICKS);

    logic [REP_W-1:0] rep_reg, rep_next, rep_inc;
    logic             rep_armed_reg, rep_armed_next;
    logic             rep_fire;

    assign rep_inc = rep_reg + 1'b1;

    // Repeat counter next-state: hold at zero outside a stable hold.
    always_comb begin
        rep_next       = rep_reg;
        rep_armed_next = rep_armed_reg;
        rep_fire       = 1'b0;
        if ((state_reg != HELD_HIGH) || !btn_sync) begin
            rep_next       = '0;
            rep_armed_next = 1'b0;
        end else if (tick) begin
            if (rep_inc >= (rep_armed_reg ? REP_PERIOD : REP_DELAY)) begin
                rep_fire       = 1'b1;
                rep_next       = '0;
                rep_armed_next = 1'b1;
            end else begin
                rep_next = rep_inc;
            end
        end
    end

    // Repeat counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_reg       <= '0;
            rep_armed_reg <= 1'b0;
        end else begin
            rep_reg       <= rep_next;
            rep_armed_reg <= rep_armed_next;
        end
    end
`endif

    // FSM next-state, stability counter, press detection and counter update.
    always_comb begin
        state_next = state_reg;
        stab_next  = stab_reg;
        count_next = count_reg;
        pulse_next = 1'b0;
        press      = 1'b0;

        case (state_reg)
            IDLE_LOW: begin
                if (btn_sync) begin
                    state_next = WAIT_HIGH;
                    stab_next  = '0;
                end
            end

            WAIT_HIGH: begin
                if (!btn_sync) begin
                    // Bounce: fall back to the stable low level.
                    state_next = IDLE_LOW;
                    stab_next  = '0;
                end else if (tick) begin
                    if (stab_inc >= STAB_DONE) begin
                        state_next = HELD_HIGH;
                        stab_next  = '0;
                        press      = 1'b1;
                    end else begin
                        stab_next = stab_inc;
                    end
                end
            end

            HELD_HIGH: begin
                if (!btn_sync) begin
                    state_next = WAIT_LOW;
                    stab_next  = '0;
                end
`ifdef BTN_AUTO_REPEAT_EN
                else if (rep_fire) begin
                    press = 1'b1;
                end
`endif
            end

            WAIT_LOW: begin
                if (btn_sync) begin
                    // Bounce on release: the button is still considered held,
                    // so returning produces no new press.
                    state_next = HELD_HIGH;
                    stab_next  = '0;
                end else if (tick) begin
                    if (stab_inc >= STAB_DONE) begin
                        state_next = IDLE_LOW;
                        stab_next  = '0;
                    end else begin
                        stab_next = stab_inc;
                    end
                end
            end

            default: begin
                state_next = IDLE_LOW;
                stab_next  = '0;
            end
        endcase

        if (press) begin
            pulse_next = 1'b1;
            count_next = count_reg + 1'b1;
        end
    end

    // FSM, stability counter, pulse and shape index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE_LOW;
            stab_reg  <= '0;
            count_reg <= '0;
            pulse_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            stab_reg  <= stab_next;
            count_reg <= count_next;
            pulse_reg <= pulse_next;
        end
    end

    assign btn_level   = (state_reg == HELD_HIGH) || (state_reg == WAIT_LOW);
    assign press_pulse = pulse_reg;
    assign count       = count_reg;

endmodule

// File: tb/tb_btn_shape_seq.sv
// Directed bench for btn_shape_seq with small timing parameters.
// Expected values are hand-derived for TICK_DIV=4, DEBOUNCE_TICKS=3,
// REPEAT_DELAY_TICKS=6, REPEAT_PERIOD_TICKS=2.
module tb_btn_shape_seq;

    localparam int TICK_DIV            = 4;
    localparam int DEBOUNCE_TICKS      = 3;
    localparam int REPEAT_DELAY_TICKS  = 6;
    localparam int REPEAT_PERIOD_TICKS = 2;
`ifdef BTN_AUTO_REPEAT_EN
    localparam int REP_ON = 1;
`else
    localparam int REP_ON = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       btnU;
    logic       btn_level;
    logic       press_pulse;
    logic [2:0] count;

    int num_checks = 0;
    int num_fails  = 0;
    int pulse_cnt  = 0;
    int level_cnt  = 0;

    btn_shape_seq #(
        .TICK_DIV            (TICK_DIV),
        .DEBOUNCE_TICKS      (DEBOUNCE_TICKS),
        .REPEAT_DELAY_TICKS  (REPEAT_DELAY_TICKS),
        .REPEAT_PERIOD_TICKS (REPEAT_PERIOD_TICKS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btnU        (btnU),
        .btn_level   (btn_level),
        .press_pulse (press_pulse),
        .count       (count)
    );

    always #5 clk = ~clk;

    // Count clk cycles with press_pulse / btn_level high.
    always @(posedge clk) begin
        if (press_pulse) pulse_cnt++;
        if (btn_level)   level_cnt++;
    end

    task automatic check(input string tag, input int got, input int exp);
        num_checks++;
        if (got !== exp) begin
            num_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        clk_wait(2);
        rst = 1'b0;
        clk_wait(2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        int l0;
        int lat;
        int found;

        rst  = 1'b1;
        btnU = 1'b0;
        clk_wait(3);
        check("rst_level", int'(btn_level), 0);
        check("rst_pulse", int'(press_pulse), 0);
        check("rst_count", int'(count), 0);
        rst = 1'b0;
        clk_wait(2);

        // Clean press: 40 clk high, then release.
        p0 = pulse_cnt;
        found = 0;
        lat = 0;
        btnU = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            clk_wait(1);
            if (found == 0 && btn_level) begin
                found = 1;
                lat = i;
            end
        end
        check("clean_rise_seen", found, 1);
        check("clean_rise_lat_in_8_20", int'(lat >= 8 && lat <= 20), 1);
        btnU = 1'b0;
        clk_wait(40);
        check("clean_pulses", pulse_cnt - p0, 1 + REP_ON);
        check("clean_count", int'(count), 1 + REP_ON);
        check("clean_release_level", int'(btn_level), 0);

        // Bounce: toggle every 5 clk for 60 clk.
        do_reset();
        p0 = pulse_cnt;
        l0 = level_cnt;
        for (int k = 0; k < 12; k++) begin
            btnU = (k % 2 == 0);
            clk_wait(5);
        end
        btnU = 1'b0;
        clk_wait(30);
        check("bounce_pulses", pulse_cnt - p0, 0);
        check("bounce_count", int'(count), 0);
        check("bounce_level_cycles", level_cnt - l0, 0);

        // Wrap: eight clean presses.
        do_reset();
        p0 = pulse_cnt;
        for (int i = 1; i <= 8; i++) begin
            btnU = 1'b1;
            clk_wait(24);
            btnU = 1'b0;
            clk_wait(24);
            check($sformatf("wrap_count_%0d", i), int'(count), i % 8);
        end
        check("wrap_pulses", pulse_cnt - p0, 8);

        // Reset in the middle of debouncing a press.
        do_reset();
        p0 = pulse_cnt;
        btnU = 1'b1;
        clk_wait(10);
        rst = 1'b1;
        clk_wait(1);
        check("midrst_level", int'(btn_level), 0);
        check("midrst_count", int'(count), 0);
        rst = 1'b0;
        clk_wait(1);
        check("midrst_pulses", pulse_cnt - p0, 0);
        clk_wait(24);
        check("midrst_hold_count", int'(count), 1);
        check("midrst_hold_pulses", pulse_cnt - p0, 1);
        btnU = 1'b0;
        clk_wait(30);

        // Long hold: 20 ticks.
        do_reset();
        p0 = pulse_cnt;
        btnU = 1'b1;
        clk_wait(80);
        btnU = 1'b0;
        clk_wait(40);
        check("hold_pulses", pulse_cnt - p0, (REP_ON != 0) ? 7 : 1);
        check("hold_count", int'(count), (REP_ON != 0) ? 7 : 1);

        // Asynchronous reset between clock edges while held.
        do_reset();
        btnU = 1'b1;
        clk_wait(24);
        check("async_pre_level", int'(btn_level), 1);
        check("async_pre_count", int'(count), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_level", int'(btn_level), 0);
        check("async_count", int'(count), 0);
        check("async_pulse", int'(press_pulse), 0);
        btnU = 1'b0;
        clk_wait(2);
        rst = 1'b0;
        clk_wait(4);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
